// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo timing constants and capture FSM encoding.
package servo_pkg;

  localparam int FRAME_BITS     = 20;
  localparam int CLK_DIV_BITS   = 8;
  localparam int OFFSET_TICKS   = 165;
  localparam int MAX_HIGH_TICKS = 1024;
  localparam int TIMEOUT_TICKS  = 8192;
  localparam int FILTER_LEN     = 4;
  localparam int TICK_W         = 12;
  localparam int WIDTH_W        = 20;

  typedef enum logic [1:0] {
    ST_LOST  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HIGH  = 2'd2,
    ST_STUCK = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pwm_in synchronizer, optional glitch filter (SERVO_CAP_FILTER_EN), edge detect.
module pwm_edge_sync
  import servo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] settle;

  // A rise only counts once a genuine low has been sampled after reset,
  // so a pulse already in progress at reset release is never decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      armed  <= 1'b0;
      settle <= 2'b00;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      prev   <= level;
      settle <= {settle[0], 1'b1};
      if (settle[1] && !sync2) armed <= 1'b1;
    end
  end

`ifdef SERVO_CAP_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             filt;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt    <= 1'b0;
      run_cnt <= '0;
    end else if (sync2 != filt) begin
      if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  assign rise = armed & level & ~prev;
  assign fall = prev & ~level;

endmodule

// File: rtl/servo_pwm_capture.sv
// rtl/servo_pwm_capture.sv - measures servo PWM high time and recovers the 8-bit position code.
module servo_pwm_capture
  import servo_pkg::*;
#(
  parameter int CLK_DIV_BITS   = servo_pkg::CLK_DIV_BITS,
  parameter int OFFSET_TICKS   = servo_pkg::OFFSET_TICKS,
  parameter int MAX_HIGH_TICKS = servo_pkg::MAX_HIGH_TICKS,
  parameter int TIMEOUT_TICKS  = servo_pkg::TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] position,
  output logic       pos_valid,
  output logic       range_err,
  output logic       signal_lost
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WIDTH_W-1:0] WIDTH_SAT = WIDTH_W'((MAX_HIGH_TICKS + 1) << CLK_DIV_BITS);
  localparam logic [WIDTH_W:0]   HALF_TICK = (WIDTH_W + 1)'(1) << (CLK_DIV_BITS - 1);

  logic                    level;
  logic                    rise;
  logic                    fall;
  cap_state_e              state;
  cap_state_e              state_next;
  logic [WIDTH_W-1:0]      width_cnt;
  logic [CLK_DIV_BITS-1:0] div_cnt;
  logic [TO_W-1:0]         timeout_cnt;
  logic                    timeout_hit;
  logic [WIDTH_W:0]        round_sum;
  logic [TICK_W-1:0]       ticks;
  logic [7:0]              conv_pos;
  logic                    conv_err;
  logic [7:0]              position_next;
  logic                    valid_next;
  logic                    err_next;
  logic                    lost_next;

  pwm_edge_sync u_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // width_cnt lags the true high time by one clock; the +1 restores it.
  assign round_sum   = {1'b0, width_cnt} + (WIDTH_W + 1)'(1) + HALF_TICK;
  assign ticks       = TICK_W'(round_sum >> CLK_DIV_BITS);
  assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_TICKS));

  always_comb begin
    conv_pos = 8'd0;
    conv_err = 1'b0;
    if (ticks < TICK_W'(OFFSET_TICKS)) begin
      conv_pos = 8'd0;
      conv_err = 1'b1;
    end else if (ticks > TICK_W'(OFFSET_TICKS + 255)) begin
      conv_pos = 8'd255;
      conv_err = 1'b1;
    end else begin
      conv_pos = 8'(ticks - TICK_W'(OFFSET_TICKS));
    end
  end

  always_comb begin
    state_next    = state;
    position_next = position;
    valid_next    = 1'b0;
    err_next      = 1'b0;
    lost_next     = signal_lost;
    case (state)
      ST_LOST: begin
        if (rise) state_next = ST_HIGH;
      end
      ST_WAIT: begin
        if (rise) begin
          state_next = ST_HIGH;
        end else if (timeout_hit) begin
          state_next = ST_LOST;
          lost_next  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (ticks > TICK_W'(MAX_HIGH_TICKS)) begin
          err_next   = 1'b1;
          state_next = fall ? ST_WAIT : ST_STUCK;
        end else if (fall) begin
          position_next = conv_pos;
          valid_next    = 1'b1;
          err_next      = conv_err;
          lost_next     = 1'b0;
          state_next    = ST_WAIT;
        end else if (timeout_hit) begin
          state_next = ST_LOST;
          lost_next  = 1'b1;
        end
      end
      ST_STUCK: begin
        if (fall) begin
          state_next = ST_WAIT;
        end else if (timeout_hit) begin
          state_next = ST_LOST;
          lost_next  = 1'b1;
        end
      end
      default: state_next = ST_LOST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOST;
      position    <= 8'd0;
      pos_valid   <= 1'b0;
      range_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_next;
      position    <= position_next;
      pos_valid   <= valid_next;
      range_err   <= err_next;
      signal_lost <= lost_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_cnt <= '0;
    end else if (state != ST_HIGH && state_next == ST_HIGH) begin
      width_cnt <= '0;
    end else if (state == ST_HIGH && level && width_cnt != WIDTH_SAT) begin
      width_cnt <= width_cnt + 1'b1;
    end
  end

  // Tick prescaler and timeout both restart on every rising edge.
  always_ff @(posedge clk) begin
    if (rst || rise) begin
      div_cnt     <= '0;
      timeout_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if ((&div_cnt) && !timeout_hit) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule
